fpu_issue_ctrl: RTL and testbench

- Issue/writeback sequencer that sits directly upstream of the fpu datapath and also collects its result.
- Accepts one FP instruction from the execute stage, registers the operands and the 3-bit op code, and holds them stable at the fpu inputs.
- Counts the per-op pipeline latency of the fpu, then captures fpu_result and presents one writeback beat.
- Stalls the core pipeline while an op is in flight; one op outstanding at a time.

---
 rtl/fpu_pkg.sv | 39 +++
 rtl/fpu_lat_lut.sv | 34 +++
 rtl/fpu_issue_ctrl.sv | 143 ++++++++++++++
 tb/tb_fpu_issue_ctrl.sv | 296 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fpu_pkg.sv
// Shared definitions for the fpu issue/writeback sequencer:
// op codes, controller states and the default per-op latencies.
package fpu_pkg;

    // Width of the latency down-counter; every latency must fit in it.
    localparam int CNT_W = 3;
    localparam int LAT_MAX = (1 << CNT_W) - 1;

    // Default destination register index width.
    localparam int RD_W_DEF = 6;

    // fpu op codes.
    localparam logic [2:0] FOP_ADD  = 3'b000;
    localparam logic [2:0] FOP_SUB  = 3'b001;
    localparam logic [2:0] FOP_MUL  = 3'b010;
    localparam logic [2:0] FOP_DIV  = 3'b011;
    localparam logic [2:0] FOP_NEG  = 3'b100;
    localparam logic [2:0] FOP_ABS  = 3'b101;
    localparam logic [2:0] FOP_SQRT = 3'b110;
    localparam logic [2:0] FOP_SLT  = 3'b111;

    // Default pipeline latencies of the fpu, in cycles from stable inputs
    // to a valid result.
    localparam int LAT_ADD_DEF  = 2;
    localparam int LAT_SUB_DEF  = 2;
    localparam int LAT_MUL_DEF  = 2;
    localparam int LAT_DIV_DEF  = 4;
    localparam int LAT_SQRT_DEF = 4;
    localparam int LAT_COMB_DEF = 0;

    // Controller states: waiting for an op, counting its latency,
    // presenting the writeback beat.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_e;

endpackage

// File: rtl/fpu_lat_lut.sv
// Combinational op-code to fpu-latency map. Kept as its own block so the
// same table can be shared by any logic that needs to know op latencies.
module fpu_lat_lut
    import fpu_pkg::*;
#(
    parameter int LAT_ADD  = LAT_ADD_DEF,
    parameter int LAT_SUB  = LAT_SUB_DEF,
    parameter int LAT_MUL  = LAT_MUL_DEF,
    parameter int LAT_DIV  = LAT_DIV_DEF,
    parameter int LAT_SQRT = LAT_SQRT_DEF,
    parameter int LAT_COMB = LAT_COMB_DEF
) (
    input  logic [2:0]       op,
    output logic [CNT_W-1:0] lat
);

    // All eight codes are defined, so the default arm is never taken; it only
    // keeps the mux fully specified.
    always_comb begin
        lat = '0;
        unique case (op)
            FOP_ADD:  lat = CNT_W'(LAT_ADD);
            FOP_SUB:  lat = CNT_W'(LAT_SUB);
            FOP_MUL:  lat = CNT_W'(LAT_MUL);
            FOP_DIV:  lat = CNT_W'(LAT_DIV);
            FOP_SQRT: lat = CNT_W'(LAT_SQRT);
            FOP_NEG,
            FOP_ABS,
            FOP_SLT:  lat = CNT_W'(LAT_COMB);
            default:  lat = '0;
        endcase
    end

endmodule

// File: rtl/fpu_issue_ctrl.sv
// Issue/writeback sequencer in front of the fpu datapath.
// Accepts one FP instruction at a time, holds its operands stable at the fpu
// inputs, waits out the op latency, captures the fpu result and presents a
// single writeback beat. The issuing stage is stalled while an op is in flight.
module fpu_issue_ctrl
    import fpu_pkg::*;
#(
    parameter int LAT_ADD  = LAT_ADD_DEF,
    parameter int LAT_SUB  = LAT_SUB_DEF,
    parameter int LAT_MUL  = LAT_MUL_DEF,
    parameter int LAT_DIV  = LAT_DIV_DEF,
    parameter int LAT_SQRT = LAT_SQRT_DEF,
    parameter int LAT_COMB = LAT_COMB_DEF,
    parameter int RD_W     = RD_W_DEF
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            issue_valid,
    input  logic [2:0]      issue_op,
    input  logic [RD_W-1:0] issue_rd,
    input  logic [31:0]     issue_a,
    input  logic [31:0]     issue_b,
    input  logic            flush,
    output logic            stall,
    output logic [2:0]      fpu_op,
    output logic [31:0]     fpu_a,
    output logic [31:0]     fpu_b,
    input  logic [31:0]     fpu_result,
    output logic            wb_valid,
    output logic [RD_W-1:0] wb_rd,
    output logic [31:0]     wb_data
);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]       fpu_op_q, fpu_op_d;
    logic [31:0]      fpu_a_q, fpu_a_d;
    logic [31:0]      fpu_b_q, fpu_b_d;
    logic [RD_W-1:0]  rd_q, rd_d;
    logic [RD_W-1:0]  wb_rd_q, wb_rd_d;
    logic [31:0]      wb_data_q, wb_data_d;
    logic [CNT_W-1:0] issue_lat;

    // Latency of the op currently offered by the execute stage.
    fpu_lat_lut #(
        .LAT_ADD  (LAT_ADD),
        .LAT_SUB  (LAT_SUB),
        .LAT_MUL  (LAT_MUL),
        .LAT_DIV  (LAT_DIV),
        .LAT_SQRT (LAT_SQRT),
        .LAT_COMB (LAT_COMB)
    ) u_lat_lut (
        .op  (issue_op),
        .lat (issue_lat)
    );

    // Next-state logic: accept in IDLE, count down in BUSY, capture on the
    // last BUSY cycle, single writeback beat in DONE. flush aborts in any
    // state and always wins over issue_valid.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        fpu_op_d  = fpu_op_q;
        fpu_a_d   = fpu_a_q;
        fpu_b_d   = fpu_b_q;
        rd_d      = rd_q;
        wb_rd_d   = wb_rd_q;
        wb_data_d = wb_data_q;

        unique case (state_q)
            IDLE: begin
                if (issue_valid && !flush) begin
                    fpu_op_d = issue_op;
                    fpu_a_d  = issue_a;
                    fpu_b_d  = issue_b;
                    rd_d     = issue_rd;
                    cnt_d    = issue_lat;
                    state_d  = BUSY;
                end
            end
            BUSY: begin
                if (flush) begin
                    // Aborted op: nothing is captured, wb_* keep old values.
                    cnt_d   = '0;
                    state_d = IDLE;
                end else if (cnt_q != '0) begin
                    cnt_d = cnt_q - CNT_W'(1);
                end else begin
                    // The fpu result has been valid for at least one cycle.
                    wb_data_d = fpu_result;
                    wb_rd_d   = rd_q;
                    state_d   = DONE;
                end
            end
            DONE: begin
                // The instruction still on issue_* here is the one retiring,
                // so it is never re-accepted from this state.
                state_d = IDLE;
            end
            default: begin
                cnt_d   = '0;
                state_d = IDLE;
            end
        endcase
    end

    // State and datapath registers; async reset drops any in-flight op.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            fpu_op_q  <= '0;
            fpu_a_q   <= '0;
            fpu_b_q   <= '0;
            rd_q      <= '0;
            wb_rd_q   <= '0;
            wb_data_q <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            fpu_op_q  <= fpu_op_d;
            fpu_a_q   <= fpu_a_d;
            fpu_b_q   <= fpu_b_d;
            rd_q      <= rd_d;
            wb_rd_q   <= wb_rd_d;
            wb_data_q <= wb_data_d;
        end
    end

    // Stall drops in DONE so the issuing instruction retires with wb_valid;
    // a flush in DONE suppresses the writeback beat.
    always_comb begin
        stall    = issue_valid && (state_q != DONE);
        wb_valid = (state_q == DONE) && !flush;
    end

    assign fpu_op  = fpu_op_q;
    assign fpu_a   = fpu_a_q;
    assign fpu_b   = fpu_b_q;
    assign wb_rd   = wb_rd_q;
    assign wb_data = wb_data_q;

endmodule

// File: tb/tb_fpu_issue_ctrl.sv
// Bench for fpu_issue_ctrl: directed scenarios followed by randomized ops,
// checked against a transaction-level model (op latency table plus a toy fpu
// whose result is only valid once the op latency has elapsed).
module tb_fpu_issue_ctrl;

    localparam int RD_W = 6;

    logic            clk = 1'b0;
    logic            rst;
    logic            issue_valid;
    logic [2:0]      issue_op;
    logic [RD_W-1:0] issue_rd;
    logic [31:0]     issue_a;
    logic [31:0]     issue_b;
    logic            flush;
    logic            stall;
    logic [2:0]      fpu_op;
    logic [31:0]     fpu_a;
    logic [31:0]     fpu_b;
    logic [31:0]     fpu_result;
    logic            wb_valid;
    logic [RD_W-1:0] wb_rd;
    logic [31:0]     wb_data;

    int checks = 0;
    int errors = 0;

    // Last value legitimately written back (what wb_* must hold).
    logic [31:0]     prev_wb_data;
    logic [RD_W-1:0] prev_wb_rd;

    always #5 clk = ~clk;

    fpu_issue_ctrl #(
        .LAT_ADD  (2),
        .LAT_SUB  (2),
        .LAT_MUL  (2),
        .LAT_DIV  (4),
        .LAT_SQRT (4),
        .LAT_COMB (0),
        .RD_W     (RD_W)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .issue_valid (issue_valid),
        .issue_op    (issue_op),
        .issue_rd    (issue_rd),
        .issue_a     (issue_a),
        .issue_b     (issue_b),
        .flush       (flush),
        .stall       (stall),
        .fpu_op      (fpu_op),
        .fpu_a       (fpu_a),
        .fpu_b       (fpu_b),
        .fpu_result  (fpu_result),
        .wb_valid    (wb_valid),
        .wb_rd       (wb_rd),
        .wb_data     (wb_data)
    );

    // Expected fpu latency per op code.
    function automatic int ref_lat(input logic [2:0] op);
        case (op)
            3'b011, 3'b110:         return 4;
            3'b100, 3'b101, 3'b111: return 0;
            default:                return 2;
        endcase
    endfunction

    // Sign-magnitude less-than for IEEE singles (NaNs ignored).
    function automatic logic flt_lt(input logic [31:0] a, input logic [31:0] b);
        if (a[31] != b[31])
            return a[31] && ((a[30:0] | b[30:0]) != 31'd0);
        else if (!a[31])
            return a[30:0] < b[30:0];
        else
            return a[30:0] > b[30:0];
    endfunction

    // Toy fpu: exact answers for the directed cases, a hash otherwise.
    function automatic logic [31:0] ref_fpu(input logic [2:0] op, input logic [31:0] a,
                                            input logic [31:0] b);
        logic [31:0] r;
        case (op)
            3'b100: r = b ^ 32'h8000_0000;
            3'b101: r = b & 32'h7FFF_FFFF;
            3'b111: r = {31'd0, flt_lt(a, b)};
            default: begin
                if (op == 3'b000 && a == 32'h3FC0_0000 && b == 32'h4010_0000)
                    r = 32'h4070_0000;
                else if (op == 3'b011 && a == 32'h40C0_0000 && b == 32'h4000_0000)
                    r = 32'h4040_0000;
                else
                    r = (a * 32'd2654435761) ^ {b[15:0], b[31:16]} ^ {29'd0, op};
            end
        endcase
        return r;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One instruction from issue to retirement. Call with the DUT idle, just
    // after a rising edge. flush_k >= 0 flushes in BUSY cycle k (0 = first);
    // flush_done flushes in the DONE cycle; wiggle scrambles issue_* while
    // stalled; hold keeps issue_valid high through DONE.
    task automatic run_op(input logic [2:0] op, input logic [RD_W-1:0] rd,
                          input logic [31:0] a, input logic [31:0] b,
                          input bit hold, input bit wiggle,
                          input int flush_k, input bit flush_done);
        int          lat;
        logic [31:0] gold;
        lat  = ref_lat(op);
        gold = ref_fpu(op, a, b);
        issue_valid = 1'b1;
        issue_op    = op;
        issue_rd    = rd;
        issue_a     = a;
        issue_b     = b;
        flush       = 1'b0;
        #1 chk("stall_idle", 32'(stall), 32'd1);
        for (int k = 0; k <= lat; k++) begin
            @(posedge clk); #1;
            // fpu result becomes valid LAT cycles after inputs are stable.
            fpu_result = (k >= lat) ? gold : $urandom;
            chk("wb_valid_busy", 32'(wb_valid), 32'd0);
            chk("fpu_op_hold", 32'(fpu_op), 32'(op));
            chk("fpu_a_hold", fpu_a, a);
            chk("fpu_b_hold", fpu_b, b);
            if (wiggle) begin
                issue_valid = 1'($urandom_range(0, 1));
                issue_op    = 3'($urandom);
                issue_rd    = RD_W'($urandom);
                issue_a     = $urandom;
                issue_b     = $urandom;
            end
            flush = (k == flush_k);
            #1 chk("stall_busy", 32'(stall), 32'(issue_valid));
            if (k == flush_k) begin
                @(posedge clk); #1;
                flush       = 1'b0;
                issue_valid = 1'b0;
                fpu_result  = $urandom;
                chk("wb_valid_flushed", 32'(wb_valid), 32'd0);
                chk("wb_data_nocap", wb_data, prev_wb_data);
                chk("wb_rd_nocap", 32'(wb_rd), 32'(prev_wb_rd));
                $display("op %0d rd %0d flushed in busy cycle %0d", op, rd, k);
                return;
            end
        end
        @(posedge clk); #1;
        fpu_result  = $urandom;
        issue_valid = hold;
        issue_op    = op;
        issue_rd    = rd;
        issue_a     = a;
        issue_b     = b;
        flush       = flush_done;
        #1;
        chk("wb_valid_done", 32'(wb_valid), 32'(!flush_done));
        chk("wb_data", wb_data, gold);
        chk("wb_rd", 32'(wb_rd), 32'(rd));
        chk("stall_done", 32'(stall), 32'd0);
        prev_wb_data = gold;
        prev_wb_rd   = rd;
        @(posedge clk); #1;
        flush       = 1'b0;
        issue_valid = 1'b0;
        chk("wb_valid_after", 32'(wb_valid), 32'd0);
        chk("wb_data_hold", wb_data, gold);
        $display("op %0d rd %0d a %h b %h -> wb %h lat %0d%s", op, rd, a, b, gold, lat,
                 flush_done ? " (flushed in done)" : "");
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst          = 1'b1;
        issue_valid  = 1'b0;
        issue_op     = '0;
        issue_rd     = '0;
        issue_a      = '0;
        issue_b      = '0;
        flush        = 1'b0;
        fpu_result   = '0;
        prev_wb_data = '0;
        prev_wb_rd   = '0;

        // Reset state.
        #3;
        chk("rst_wb_valid", 32'(wb_valid), 32'd0);
        chk("rst_fpu_op", 32'(fpu_op), 32'd0);
        chk("rst_fpu_a", fpu_a, 32'd0);
        chk("rst_fpu_b", fpu_b, 32'd0);
        chk("rst_wb_rd", 32'(wb_rd), 32'd0);
        chk("rst_wb_data", wb_data, 32'd0);
        chk("rst_stall_lo", 32'(stall), 32'd0);
        issue_valid = 1'b1;
        #1 chk("rst_stall_hi", 32'(stall), 32'd1);
        issue_valid = 1'b0;
        @(posedge clk); @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
        $display("reset checked");

        // Directed ops, back-to-back where the previous one leaves off.
        run_op(3'b000, 6'd3, 32'h3FC0_0000, 32'h4010_0000, 1'b0, 1'b0, -1, 1'b0);
        run_op(3'b011, 6'd7, 32'h40C0_0000, 32'h4000_0000, 1'b1, 1'b0, -1, 1'b0);
        run_op(3'b100, 6'd9, 32'h0000_0000, 32'h3F80_0000, 1'b1, 1'b0, -1, 1'b0);
        run_op(3'b111, 6'd10, 32'hBF80_0000, 32'h3F80_0000, 1'b1, 1'b0, -1, 1'b0);

        // flush in IDLE blocks acceptance: no writeback may follow.
        issue_valid = 1'b1;
        issue_op    = 3'b000;
        issue_a     = 32'h1234_5678;
        issue_b     = 32'h9ABC_DEF0;
        flush       = 1'b1;
        #1 chk("idle_flush_stall", 32'(stall), 32'd1);
        @(posedge clk); #1;
        issue_valid = 1'b0;
        flush       = 1'b0;
        for (int i = 0; i < 5; i++) begin
            chk("idle_flush_no_wb", 32'(wb_valid), 32'd0);
            @(posedge clk); #1;
        end
        $display("idle flush blocked acceptance");

        // Flush a mul in its 2nd BUSY cycle, then an add right after.
        run_op(3'b010, 6'd12, 32'h4000_0000, 32'h4040_0000, 1'b1, 1'b0, 1, 1'b0);
        run_op(3'b000, 6'd13, 32'h3FC0_0000, 32'h4010_0000, 1'b0, 1'b0, -1, 1'b0);
        // Flush in DONE, then flush on the capture cycle of a div.
        run_op(3'b001, 6'd14, 32'h1111_1111, 32'h2222_2222, 1'b0, 1'b0, -1, 1'b1);
        run_op(3'b011, 6'd15, 32'h3333_3333, 32'h4444_4444, 1'b1, 1'b0, 4, 1'b0);
        run_op(3'b101, 6'd16, 32'h0, 32'hC0A0_0000, 1'b0, 1'b0, -1, 1'b0);

        // Async reset in the middle of a sqrt.
        issue_valid = 1'b1;
        issue_op    = 3'b110;
        issue_rd    = 6'd21;
        issue_a     = 32'h4110_0000;
        issue_b     = 32'h0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        #2 rst = 1'b1;
        #1;
        chk("arst_wb_valid", 32'(wb_valid), 32'd0);
        chk("arst_fpu_op", 32'(fpu_op), 32'd0);
        chk("arst_fpu_a", fpu_a, 32'd0);
        chk("arst_wb_data", wb_data, 32'd0);
        chk("arst_wb_rd", 32'(wb_rd), 32'd0);
        chk("arst_stall", 32'(stall), 32'd1);
        @(posedge clk); #1;
        chk("arst_hold_wb_valid", 32'(wb_valid), 32'd0);
        rst          = 1'b0;
        prev_wb_data = '0;
        prev_wb_rd   = '0;
        $display("async reset mid-sqrt checked");
        run_op(3'b110, 6'd21, 32'h4110_0000, 32'h0, 1'b0, 1'b0, -1, 1'b0);

        // Randomized ops with idle gaps, scrambled inputs and flushes.
        for (int n = 0; n < 40; n++) begin
            logic [2:0] op;
            int         fk;
            bit         fd;
            int         gap;
            op  = 3'($urandom);
            fk  = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, ref_lat(op))) : -1;
            fd  = (fk < 0) && ($urandom_range(0, 7) == 0);
            gap = $urandom_range(0, 2);
            for (int g = 0; g < gap; g++) begin
                issue_valid = 1'($urandom_range(0, 1));
                flush       = issue_valid ? 1'b1 : 1'($urandom_range(0, 1));
                #1 chk("gap_stall", 32'(stall), 32'(issue_valid));
                @(posedge clk); #1;
                chk("gap_wb_valid", 32'(wb_valid), 32'd0);
            end
            issue_valid = 1'b0;
            flush       = 1'b0;
            run_op(op, RD_W'($urandom), $urandom, $urandom,
                   1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), fk, fd);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
